uv_apb_mst: RTL and testbench

UV_APB_MST -- requirements
Module: uv_apb_mst

---
 rtl/uv_apb_mst.sv | 161 ++++++++++++++++
 tb/tb_uv_apb_mst.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uv_apb_mst.sv
// APB initiator: turns one request into a single SETUP/ACCESS transfer and
// returns the slave's data, error flag or a timeout as one response.
module uv_apb_mst #(
  parameter int ALEN    = 12,
  parameter int DLEN    = 32,
  parameter int MLEN    = DLEN / 8,
  parameter int TMO_CYC = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic            req_read,
  input  logic [ALEN-1:0] req_addr,
  input  logic [MLEN-1:0] req_mask,
  input  logic [DLEN-1:0] req_data,
  input  logic [2:0]      req_prot,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic            rsp_excp,
  output logic [DLEN-1:0] rsp_data,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [2:0]      pprot,
  output logic [ALEN-1:0] paddr,
  output logic [MLEN-1:0] pstrb,
  output logic [DLEN-1:0] pwdata,
  input  logic [DLEN-1:0] prdata,
  input  logic            pready,
  input  logic            pslverr
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_rdy_q, req_rdy_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_excp_q, rsp_excp_d;
  logic [DLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [2:0]        pprot_q, pprot_d;
  logic [ALEN-1:0]   paddr_q, paddr_d;
  logic [MLEN-1:0]   pstrb_q, pstrb_d;
  logic [DLEN-1:0]   pwdata_q, pwdata_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_rdy_d  = req_rdy_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_excp_d = rsp_excp_q;
    rsp_data_d = rsp_data_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    pprot_d    = pprot_q;
    paddr_d    = paddr_q;
    pstrb_d    = pstrb_q;
    pwdata_d   = pwdata_q;
    case (state_q)
      IDLE: begin
        req_rdy_d = 1'b1;
        if (req_vld) begin
          // Reads never expose write data or strobes on the bus.
          state_d   = SETUP;
          req_rdy_d = 1'b0;
          psel_d    = 1'b1;
          pwrite_d  = ~req_read;
          pprot_d   = req_prot;
          paddr_d   = req_addr;
          pstrb_d   = req_read ? '0 : req_mask;
          pwdata_d  = req_read ? '0 : req_data;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d    = RESP;
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_excp_d = pslverr;
          rsp_data_d = pwrite_q ? '0 : prdata;
        end else if (cnt_q == CNT_LIM) begin
          state_d    = RESP;
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_excp_d = 1'b1;
          rsp_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          state_d   = IDLE;
          rsp_vld_d = 1'b0;
          req_rdy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_rdy_q  <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_excp_q <= 1'b0;
      rsp_data_q <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      pprot_q    <= '0;
      paddr_q    <= '0;
      pstrb_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_rdy_q  <= req_rdy_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_excp_q <= rsp_excp_d;
      rsp_data_q <= rsp_data_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      pprot_q    <= pprot_d;
      paddr_q    <= paddr_d;
      pstrb_q    <= pstrb_d;
      pwdata_q   <= pwdata_d;
    end
  end

  assign req_rdy  = req_rdy_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_excp = rsp_excp_q;
  assign rsp_data = rsp_data_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign pprot    = pprot_q;
  assign paddr    = paddr_q;
  assign pstrb    = pstrb_q;
  assign pwdata   = pwdata_q;

endmodule

// File: tb/tb_uv_apb_mst.sv
// Bench for uv_apb_mst: open-loop directed transfers, with a per-cycle model
// that derives every output from the transfer's offset since acceptance.
module tb_uv_apb_mst;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld, req_rdy, req_read;
  logic [11:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_data;
  logic [2:0]  req_prot;
  logic        rsp_vld, rsp_rdy, rsp_excp;
  logic [31:0] rsp_data;
  logic        psel, penable, pwrite;
  logic [2:0]  pprot;
  logic [11:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  uv_apb_mst #(.ALEN(12), .DLEN(32), .MLEN(4), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_read(req_read),
    .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .req_prot(req_prot),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_excp(rsp_excp),
    .rsp_data(rsp_data),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot),
    .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Current transfer descriptor; k is the cycle offset from the accept cycle.
  bit          active = 1'b0;
  int          k = -1;
  bit          t_read, t_slverr, t_tmo;
  logic [11:0] t_addr;
  logic [3:0]  t_mask;
  logic [31:0] t_data, t_rdata;
  logic [2:0]  t_prot;
  int          t_r, t_last;

  bit          seen_vld;
  int          first_vld_k, acc_cnt;
  logic [31:0] obs_data;
  logic        obs_excp;
  logic [3:0]  obs_pstrb;

  // Model: accept at k=0, SETUP at k=1, ACCESS k=2..t_r-1, RESP k>=t_r.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!active) begin
        chk("idle_req_rdy", req_rdy, 1);
        chk("idle_rsp_vld", rsp_vld, 0);
        chk("idle_psel", psel, 0);
        chk("idle_penable", penable, 0);
      end else begin
        chk("req_rdy", req_rdy, k == 0);
        chk("psel", psel, (k >= 1) && (k < t_r));
        chk("penable", penable, (k >= 2) && (k < t_r));
        chk("rsp_vld", rsp_vld, k >= t_r);
        if (k >= 1 && k < t_r) begin
          chk("paddr", paddr, t_addr);
          chk("pwrite", pwrite, !t_read);
          chk("pstrb", pstrb, t_read ? 4'h0 : t_mask);
          chk("pwdata", pwdata, t_read ? 32'h0 : t_data);
          chk("pprot", pprot, t_prot);
        end
        if (k >= t_r) begin
          chk("rsp_excp", rsp_excp, t_tmo ? 1'b1 : t_slverr);
          chk("rsp_data", rsp_data, (t_tmo || t_read == 1'b0) ? 32'h0 : t_rdata);
        end
        if (k == 1) obs_pstrb = pstrb;
        if (psel && penable) acc_cnt++;
        if (rsp_vld && !seen_vld) begin
          seen_vld = 1'b1;
          first_vld_k = k;
        end
        if (rsp_vld) begin
          obs_data = rsp_data;
          obs_excp = rsp_excp;
        end
      end
    end
  end

  task automatic idle_inputs(input bit keep_vld);
    if (!keep_vld) req_vld = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    rsp_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // wt: ACCESS wait cycles before pready (wt>=TMO means the slave never answers).
  // hold: RESP cycles with rsp_rdy=0. noise: spurious pready/pslverr/rsp_rdy
  // outside the cycles where they matter. abort_k: assert reset after that cycle.
  task automatic do_xfer(input bit rd, input logic [11:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [2:0] prot, input int wt,
                         input bit serr, input logic [31:0] rdata, input int hold,
                         input bit hold_vld, input bit noise, input int abort_k);
    int acc;
    t_read = rd; t_addr = addr; t_mask = mask; t_data = data; t_prot = prot;
    t_slverr = serr; t_rdata = rdata;
    t_tmo = (wt >= TMO);
    acc = t_tmo ? TMO : wt + 1;
    t_r = 2 + acc;
    t_last = t_r + hold;
    seen_vld = 1'b0; first_vld_k = -1; acc_cnt = 0;
    for (int kk = 0; kk <= t_last; kk++) begin
      k = kk;
      active = 1'b1;
      req_vld = (kk == 0) || hold_vld;
      if (kk == 0) begin
        req_read = rd; req_addr = addr; req_mask = mask; req_data = data; req_prot = prot;
      end else begin
        req_read = ~rd; req_addr = ~addr; req_mask = ~mask; req_data = ~data; req_prot = ~prot;
      end
      pready  = (!t_tmo && kk == 2 + wt) || (noise && (kk < 2 || kk >= t_r));
      pslverr = (kk == 2 + wt) ? serr : noise;
      prdata  = (kk == 2 + wt) ? rdata : 32'hDEAD_BEEF;
      rsp_rdy = (kk == t_last) || (noise && kk < t_r);
      @(negedge clk);
      if (kk == abort_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        active = 1'b0;
        k = -1;
        idle_inputs(1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    active = 1'b0;
    k = -1;
    idle_inputs(hold_vld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_vld = 1'b0; req_read = 1'b0; req_addr = '0; req_mask = '0; req_data = '0; req_prot = '0;
    idle_inputs(1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_excp", rsp_excp, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pprot", pprot, 0);
    @(posedge clk);
    #1;

    // Zero-wait write.
    do_xfer(1'b0, 12'h01C, 4'hF, 32'h0000_00A5, 3'b010, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0, -1);
    chk("wr_latency", first_vld_k, 3);
    chk("wr_pstrb", obs_pstrb, 4'hF);
    chk("wr_excp", obs_excp, 0);
    chk("wr_acc_cycles", acc_cnt, 1);
    $display("txn write 0x01C done: rsp at k=%0d", first_vld_k);
    idle(1);

    // Read with 3 wait states; pready lands on the counter-limit cycle.
    do_xfer(1'b1, 12'h008, 4'hF, 32'hFFFF_FFFF, 3'b000, 3, 1'b0, 32'h1234_5678, 0, 1'b0, 1'b0, -1);
    chk("rd_latency", first_vld_k, 6);
    chk("rd_data", obs_data, 32'h1234_5678);
    chk("rd_pstrb", obs_pstrb, 4'h0);
    chk("rd_acc_cycles", acc_cnt, 4);
    $display("txn read 0x008 done: data=%08h", obs_data);
    idle(2);

    // Read with slave error, plus spurious slave/response signals.
    do_xfer(1'b1, 12'h100, 4'h3, 32'h0000_0055, 3'b111, 1, 1'b1, 32'h1234_5678, 2, 1'b0, 1'b1, -1);
    chk("err_excp", obs_excp, 1);
    chk("err_data", obs_data, 32'h1234_5678);
    chk("err_latency", first_vld_k, 4);
    $display("txn read 0x100 slverr done: excp=%0d", obs_excp);
    idle(1);

    // Slave never answers: timeout after exactly TMO ACCESS cycles.
    do_xfer(1'b0, 12'h3FC, 4'h5, 32'hCAFE_F00D, 3'b001, 10, 1'b0, 32'h0, 1, 1'b0, 1'b0, -1);
    chk("tmo_acc_cycles", acc_cnt, 4);
    chk("tmo_latency", first_vld_k, 6);
    chk("tmo_excp", obs_excp, 1);
    chk("tmo_data", obs_data, 0);
    $display("txn write 0x3FC timeout done: excp=%0d", obs_excp);

    // Timeout on a read, pready would arrive one cycle too late.
    do_xfer(1'b1, 12'h044, 4'h0, 32'h0, 3'b000, 4, 1'b0, 32'h0000_ABCD, 0, 1'b0, 1'b1, -1);
    chk("tmo_rd_data", obs_data, 0);
    chk("tmo_rd_acc", acc_cnt, 4);
    $display("txn read 0x044 timeout done: data=%08h", obs_data);
    idle(1);

    // Long back-pressure with req_vld held, then a back-to-back read.
    do_xfer(1'b0, 12'h200, 4'h3, 32'h1111_2222, 3'b100, 0, 1'b0, 32'h0, 10, 1'b1, 1'b0, -1);
    chk("bp_latency", first_vld_k, 3);
    $display("txn write 0x200 backpressure done");
    do_xfer(1'b1, 12'h204, 4'hF, 32'h0, 3'b000, 0, 1'b0, 32'h8765_4321, 0, 1'b0, 1'b0, -1);
    chk("b2b_latency", first_vld_k, 3);
    chk("b2b_data", obs_data, 32'h8765_4321);
    $display("txn read 0x204 back-to-back done: data=%08h", obs_data);
    idle(1);

    // Reset during ACCESS: no response afterwards.
    do_xfer(1'b1, 12'h0F0, 4'hF, 32'h0, 3'b000, 10, 1'b0, 32'h0, 0, 1'b0, 1'b0, 3);
    seen_vld = 1'b0;
    idle(4);
    chk("post_rst_req_rdy", req_rdy, 1);
    chk("post_rst_rsp_vld", rsp_vld, 0);
    $display("txn read 0x0F0 aborted by reset");

    // Normal traffic after reset recovery.
    do_xfer(1'b0, 12'hABC, 4'h6, 32'h0BAD_F00D, 3'b011, 2, 1'b0, 32'h0, 1, 1'b0, 1'b0, -1);
    chk("post_latency", first_vld_k, 5);
    chk("post_excp", obs_excp, 0);
    $display("txn write 0xABC after reset done: rsp at k=%0d", first_vld_k);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
